// File: rtl/irq_agg_pkg.sv
// Shared definitions for the interrupt aggregator: register map, FSM states,
// bus request payload and the lowest-index priority encoder.
package irq_agg_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned VEC_IDX_W     = 4;
    localparam int unsigned VEC_VALID_BIT = 15;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PEND    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_HOLDOFF = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mm_req_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [VEC_IDX_W-1:0] lowest_index(input logic [DATA_W-1:0] v);
        logic [VEC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            if (v[i]) idx = VEC_IDX_W'(i);
        end
        return idx;
    endfunction

    // VECTOR register image: valid flag plus lowest active index, all zero when idle.
    function automatic logic [DATA_W-1:0] vector_word(input logic [DATA_W-1:0] active);
        logic [DATA_W-1:0] w;
        w = '0;
        if (|active) begin
            w[VEC_VALID_BIT]   = 1'b1;
            w[VEC_IDX_W-1:0]   = lowest_index(active);
        end
        return w;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit input synchroniser followed by a one-cycle-delayed copy for rising-edge detection.
module irq_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] irq_in,
    output logic [WIDTH-1:0] sin_c,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] sin_d;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sin_c = irq_in;
    end else begin : g_sync
        logic [WIDTH-1:0] stage_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
            end else begin
                stage_q[0] <= irq_in;
                for (int unsigned s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
            end
        end

        assign sin_c = stage_q[SYNC_STAGES-1];
    end

    // sin_d resets low so a source already high at release reads as a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sin_d <= '0;
        else          sin_d <= sin_c;
    end

    assign rise_c = sin_c & ~sin_d;

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: masks, latches and prioritises up to 15 sources
// into a single CPU irq with an optional hold-off window after each deassertion.
module irq_aggregator
    import irq_agg_pkg::*;
#(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    input  logic [N_SRC-1:0]  irq_in,
    output logic              irq_out
);

    mm_req_t              req_c;
    logic [N_SRC-1:0]     sin_c;
    logic [N_SRC-1:0]     rise_c;
    logic [N_SRC-1:0]     pend_q;
    logic [N_SRC-1:0]     pend_d;
    logic [N_SRC-1:0]     enable_q;
    logic [N_SRC-1:0]     edge_q;
    logic [N_SRC-1:0]     active_c;
    logic [N_SRC-1:0]     w1c_c;
    logic [HOLDOFF_W-1:0] holdoff_q;
    logic [HOLDOFF_W-1:0] cnt_q;
    logic [HOLDOFF_W-1:0] cnt_d;
    logic                 gen_q;
    logic                 any_c;
    logic                 irq_out_d;
    logic [DATA_W-1:0]    readdata_d;
    irq_state_e           state_q;
    irq_state_e           state_d;

    always_comb begin
        req_c.we    = chipselect & ~write_n;
        req_c.addr  = address;
        req_c.wdata = writedata;
    end

    irq_sync_edge #(
        .WIDTH       (N_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .sin_c   (sin_c),
        .rise_c  (rise_c)
    );

    // Configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q  <= '0;
            edge_q    <= '0;
            holdoff_q <= '0;
            gen_q     <= 1'b0;
        end else if (req_c.we) begin
            case (req_c.addr)
                ADDR_ENABLE:  enable_q  <= req_c.wdata[N_SRC-1:0];
                ADDR_EDGE:    edge_q    <= req_c.wdata[N_SRC-1:0];
                ADDR_HOLDOFF: holdoff_q <= req_c.wdata[HOLDOFF_W-1:0];
                ADDR_CTRL:    gen_q     <= req_c.wdata[0];
                default: ;
            endcase
        end
    end

    // Pending: level bits track the input; edge bits latch until W1C, with set beating clear.
    always_comb begin
        w1c_c  = (req_c.we && req_c.addr == ADDR_PEND) ? req_c.wdata[N_SRC-1:0] : '0;
        pend_d = pend_q;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!edge_q[i])     pend_d[i] = sin_c[i];
            else if (rise_c[i]) pend_d[i] = 1'b1;
            else if (w1c_c[i])  pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    assign active_c = pend_q & enable_q;
    assign any_c    = gen_q & (|active_c);

    // Irq FSM: state register and hold-off counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the hold-off countdown ignores any and GEN once started.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_c) state_d = ASSERT;
            end
            ASSERT: begin
                if (!any_c) begin
                    if (holdoff_q != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = holdoff_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                cnt_d = cnt_q - HOLDOFF_W'(1);
                if (cnt_q <= HOLDOFF_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so irq_out lines up with the state register.
    always_comb begin
        irq_out_d = (state_d == ASSERT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_out <= 1'b0;
        else          irq_out <= irq_out_d;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS:  readdata_d = DATA_W'(sin_c);
            ADDR_PEND:    readdata_d = DATA_W'(pend_q);
            ADDR_ENABLE:  readdata_d = DATA_W'(enable_q);
            ADDR_EDGE:    readdata_d = DATA_W'(edge_q);
            ADDR_ACTIVE:  readdata_d = DATA_W'(active_c);
            ADDR_VECTOR:  readdata_d = vector_word(DATA_W'(active_c));
            ADDR_HOLDOFF: readdata_d = DATA_W'(holdoff_q);
            ADDR_CTRL:    readdata_d = DATA_W'(gen_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= readdata_d;
    end

endmodule
